// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receiver: FSM state encoding and the FIFO entry layout.
package uart_pkg;

    // Widest supported frame payload; narrower frames zero-fill the upper bits.
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    typedef struct packed {
        logic                     frame_err;
        logic                     parity_err;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bus of the UART receiver: pop/clear controls and head-entry status.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 rd_en;
    logic                 clr_err;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rdy;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic [CW-1:0]        fifo_cnt;

    // Consumer drives pops and error clears.
    modport master (
        output rd_en, clr_err,
        input  rx_data, rdy, frame_err, parity_err, overrun, fifo_cnt
    );

    // Receiver presents head entry and status.
    modport slave (
        input  rd_en, clr_err,
        output rx_data, rdy, frame_err, parity_err, overrun, fifo_cnt
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with registered first-word fall-through head.
// The head register only moves on a pop or when the FIFO fills from empty,
// so the output holds its last value while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic             w_push;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_cnt   = r_cnt;
    assign o_rd_data = r_head;

    // A write into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign w_pop        = i_rd_en && !o_empty;
    assign w_push       = i_wr_en && (!o_full || w_pop);
    assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    assign w_cnt_nxt    = r_cnt + CW'(w_push) - CW'(w_pop);

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr <= w_rd_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Head register; bypass the write data when the new head is the slot being written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
        end else if (w_cnt_nxt != '0 && (w_pop || o_empty)) begin
            r_head <= (w_push && r_wr_ptr == w_rd_ptr_nxt) ? i_wr_data : r_mem[w_rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled mid-bit sampling, optional parity,
// break handling and a receive FIFO with sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           RX,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [15:0] BAUD_FULL = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2 - 1);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [15:0]          r_baud_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_overrun;

    logic                 w_sample;
    logic                 w_last_bit;
    logic                 w_par_calc;
    logic                 w_push;
    rx_entry_t            w_entry;
    rx_entry_t            w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_unused_head;

    // Samples land in the middle of each bit once the half-bit offset from the start edge is applied.
    assign w_sample   = (r_state == START || r_state == DATA || r_state == PARITY || r_state == STOP)
                        && (r_baud_cnt == '0);
    assign w_last_bit = (r_bit_cnt == 4'(DATA_BITS - 1));
    assign w_par_calc = (^r_shift) ^ r_rx_sync ^ PARITY_ODD[0];

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and FIFO push decode.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_entry     = '0;
        w_entry.data[DATA_BITS-1:0] = r_shift;
        w_entry.parity_err          = r_par_err;
        w_entry.frame_err           = ~r_rx_sync;
        case (r_state)
            IDLE:     if (!r_rx_sync) w_state_nxt = START;
            START:    if (w_sample) w_state_nxt = r_rx_sync ? IDLE : DATA;
            DATA:     if (w_sample && w_last_bit) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:   if (w_sample) w_state_nxt = STOP;
            STOP: begin
                if (w_sample) begin
                    w_push      = 1'b1;
                    w_state_nxt = r_rx_sync ? IDLE : BRK_WAIT;
                end
            end
            BRK_WAIT: if (r_rx_sync) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Baud counter: half-bit load on the start edge, full-bit reload on every sample, frozen while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt <= '0;
        end else begin
            case (r_state)
                IDLE:                     if (!r_rx_sync) r_baud_cnt <= BAUD_HALF;
                START, DATA, PARITY, STOP: r_baud_cnt <= w_sample ? BAUD_FULL : r_baud_cnt - 16'd1;
                default:                  r_baud_cnt <= r_baud_cnt;
            endcase
        end
    end

    // Bit counter, LSB-first shift register and frame parity result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '1;
            r_par_err <= 1'b0;
        end else if (w_sample) begin
            case (r_state)
                START: begin
                    r_bit_cnt <= '0;
                    r_par_err <= 1'b0;
                end
                DATA: begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                end
                PARITY:  r_par_err <= (PARITY_EN != 0) ? w_par_calc : 1'b0;
                default: r_bit_cnt <= r_bit_cnt;
            endcase
        end
    end

    // Sticky overrun: a frame dropped on a full FIFO without a same-cycle pop; set beats clear.
    always_ff @(posedge clk) begin
        if (rst)                                   r_overrun <= 1'b0;
        else if (w_push && w_full && !bus.rd_en)   r_overrun <= 1'b1;
        else if (bus.clr_err)                      r_overrun <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_entry),
        .i_rd_en   (bus.rd_en),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_cnt     (bus.fifo_cnt)
    );

    // Padding bits of the entry beyond DATA_BITS are intentionally dropped.
    assign w_unused_head  = ^w_head;

    assign bus.rx_data    = w_head.data[DATA_BITS-1:0];
    assign bus.frame_err  = w_head.frame_err;
    assign bus.parity_err = w_head.parity_err;
    assign bus.rdy        = ~w_empty;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 and an 8E1 instance at 16 clocks per bit.
module tb_uart_rx_fifo;
    localparam int BD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();

    uart_rx_fifo #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4))
        dut0 (.clk(clk), .rst(rst), .RX(rx0), .bus(if0));
    uart_rx_fifo #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4))
        dut1 (.clk(clk), .rst(rst), .RX(rx1), .bus(if1));

    int n_pass = 0;
    int n_tot  = 0;
    int cyc;
    int rdy_cyc;

    typedef struct {
        int         d;
        logic [7:0] dat;
        logic       par;
        logic       stp;
        logic [7:0] e_dat;
        logic       e_fe;
        logic       e_pe;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       fe;
    } ent_t;

    vec_t tbl [8];
    ent_t q [$];
    logic m_ovr;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (if0.rdy && rdy_cyc < 0) rdy_cyc = cyc;
    endtask

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx0 = v;
        else        rx1 = v;
    endtask

    task automatic rd(input int d, output int rdy, output int dat, output int fe,
                      output int pe, output int cnt, output int ovr);
        if (d == 0) begin
            rdy = int'(if0.rdy); dat = int'(if0.rx_data); fe = int'(if0.frame_err);
            pe = int'(if0.parity_err); cnt = int'(if0.fifo_cnt); ovr = int'(if0.overrun);
        end else begin
            rdy = int'(if1.rdy); dat = int'(if1.rx_data); fe = int'(if1.frame_err);
            pe = int'(if1.parity_err); cnt = int'(if1.fifo_cnt); ovr = int'(if1.overrun);
        end
    endtask

    // Drive n frame bits (index 0 = start bit), optional extra low bit times, then idle high.
    // pop_at/clr_at pulse dut0 rd_en/clr_err so they are sampled on that edge count.
    task automatic send(input int d, input logic [11:0] bits, input int n, input int low_after,
                        input int pop_at, input int clr_at);
        cyc = 0;
        rdy_cyc = -1;
        for (int b = 0; b < n + low_after; b++) begin
            set_rx(d, (b < n) ? bits[b] : 1'b0);
            for (int k = 0; k < BD; k++) begin
                if0.rd_en   = (pop_at > 0 && cyc == pop_at - 1);
                if0.clr_err = (clr_at > 0 && cyc == clr_at - 1);
                tick;
            end
        end
        if0.rd_en = 1'b0;
        if0.clr_err = 1'b0;
        set_rx(d, 1'b1);
        repeat (6) tick;
    endtask

    function automatic logic [11:0] f8n1(input logic [7:0] dat, input logic stp);
        return {3'b111, stp, dat, 1'b0};
    endfunction

    function automatic logic [11:0] f8e1(input logic [7:0] dat, input logic par, input logic stp);
        return {2'b11, stp, par, dat, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] dat);
        send(0, f8n1(dat, 1'b1), 10, 0, 0, 0);
    endtask

    task automatic pop(input int d);
        if (d == 0) if0.rd_en = 1'b1;
        else        if1.rd_en = 1'b1;
        tick;
        if0.rd_en = 1'b0;
        if1.rd_en = 1'b0;
    endtask

    task automatic chk_pop(input string nm, input int exp_dat);
        chk(nm, int'(if0.rx_data), exp_dat);
        pop(0);
    endtask

    initial begin
        int rdy, dat, fe, pe, cnt, ovr;
        logic [11:0] fr;
        logic [7:0]  rb;
        logic        rs;

        if0.rd_en = 1'b0; if0.clr_err = 1'b0;
        if1.rd_en = 1'b0; if1.clr_err = 1'b0;

        tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[4] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
        tbl[5] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        tbl[6] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
        tbl[7] = '{1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};

        repeat (3) tick;
        for (int d = 0; d < 2; d++) begin
            rd(d, rdy, dat, fe, pe, cnt, ovr);
            chk("reset rdy", rdy, 0);
            chk("reset cnt", cnt, 0);
            chk("reset ovr", ovr, 0);
            chk("reset data/flags", dat + fe + pe, 0);
        end
        rst = 1'b0;

        // Table-driven single frames on both instances.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].d == 0) send(0, f8n1(tbl[i].dat, tbl[i].stp), 10, 0, 0, 0);
            else               send(1, f8e1(tbl[i].dat, tbl[i].par, tbl[i].stp), 11, 0, 0, 0);
            if (i == 0) chk("latency rdy cycle", rdy_cyc, 155);
            rd(tbl[i].d, rdy, dat, fe, pe, cnt, ovr);
            chk($sformatf("vec%0d rdy", i), rdy, 1);
            chk($sformatf("vec%0d cnt", i), cnt, 1);
            chk($sformatf("vec%0d data", i), dat, int'(tbl[i].e_dat));
            chk($sformatf("vec%0d frame_err", i), fe, int'(tbl[i].e_fe));
            chk($sformatf("vec%0d parity_err", i), pe, int'(tbl[i].e_pe));
            pop(tbl[i].d);
            rd(tbl[i].d, rdy, dat, fe, pe, cnt, ovr);
            chk($sformatf("vec%0d empty after pop", i), rdy, 0);
            chk($sformatf("vec%0d held data", i), dat, int'(tbl[i].e_dat));
        end

        // False start: 4-clock low glitch.
        rx0 = 1'b0;
        repeat (4) tick;
        rx0 = 1'b1;
        repeat (200) tick;
        chk("false start rdy", int'(if0.rdy), 0);
        chk("false start cnt", int'(if0.fifo_cnt), 0);

        // Break: stop bit low and line held low 3 more bit times.
        send(0, f8n1(8'h00, 1'b0), 10, 3, 0, 0);
        repeat (200) tick;
        chk("break cnt", int'(if0.fifo_cnt), 1);
        chk("break frame_err", int'(if0.frame_err), 1);
        chk_pop("break data", 0);

        // Overrun: five frames into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i * 8'h11));
            if (i == 4) chk("ovr before full drop", int'(if0.overrun), 0);
        end
        chk("ovr set", int'(if0.overrun), 1);
        chk("ovr cnt", int'(if0.fifo_cnt), 4);
        for (int i = 1; i <= 4; i++) chk_pop($sformatf("ovr pop%0d", i), i * 'h11);
        chk("ovr drained", int'(if0.rdy), 0);
        pop(0);
        chk("pop empty cnt", int'(if0.fifo_cnt), 0);
        if0.clr_err = 1'b1; tick; if0.clr_err = 1'b0;
        chk("ovr cleared", int'(if0.overrun), 0);

        // Full FIFO with push and pop on the same edge.
        for (int i = 1; i <= 4; i++) send_byte(8'(i * 8'h11));
        send(0, f8n1(8'h55, 1'b1), 10, 0, 155, 0);
        chk("full push+pop ovr", int'(if0.overrun), 0);
        chk("full push+pop cnt", int'(if0.fifo_cnt), 4);
        for (int i = 2; i <= 5; i++) chk_pop($sformatf("push+pop pop%0d", i), i * 'h11);

        // Overrun set and clear on the same edge.
        for (int i = 1; i <= 4; i++) send_byte(8'(8'h60 + i));
        send(0, f8n1(8'h65, 1'b1), 10, 0, 0, 155);
        chk("set beats clear", int'(if0.overrun), 1);

        // Reset during data bit 3 with FIFO full and overrun set.
        fr = f8n1(8'h5A, 1'b1);
        cyc = 0;
        for (int c = 0; c < 70; c++) begin
            rx0 = fr[c / BD];
            tick;
        end
        rst = 1'b1;
        rx0 = 1'b1;
        tick;
        rst = 1'b0;
        rd(0, rdy, dat, fe, pe, cnt, ovr);
        chk("midreset rdy", rdy, 0);
        chk("midreset cnt", cnt, 0);
        chk("midreset ovr", ovr, 0);
        chk("midreset data", dat, 0);
        chk("midreset flags", fe + pe, 0);
        repeat (10) tick;
        send_byte(8'h5A);
        chk("post reset cnt", int'(if0.fifo_cnt), 1);
        chk_pop("post reset data", 'h5A);

        // Randomized traffic against a queue model.
        m_ovr = 1'b0;
        for (int it = 0; it < 30; it++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send(0, f8n1(rb, rs), 10, 0, 0, 0);
            if (q.size() < 4) q.push_back('{rb, ~rs});
            else              m_ovr = 1'b1;
            chk("rand cnt", int'(if0.fifo_cnt), q.size());
            chk("rand ovr", int'(if0.overrun), int'(m_ovr));
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                if (q.size() > 0) begin
                    chk("rand data", int'(if0.rx_data), int'(q[0].d));
                    chk("rand frame_err", int'(if0.frame_err), int'(q[0].fe));
                    void'(q.pop_front());
                end else begin
                    chk("rand empty rdy", int'(if0.rdy), 0);
                end
                pop(0);
                chk("rand pop cnt", int'(if0.fifo_cnt), q.size());
            end
            if ($urandom_range(0, 5) == 0) begin
                if0.clr_err = 1'b1; tick; if0.clr_err = 1'b0;
                m_ovr = 1'b0;
                chk("rand clr ovr", int'(if0.overrun), 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
